// File: rtl/_univ_reg_r.sv
// Universal WIDTH-bit register: load, shift, rotate, increment and decrement,
// with asynchronous active-low reset and synchronous active-low set.
module _univ_reg_r #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             co,
  output logic             zero
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  mode_e op;
  assign op = mode_e'(mode);

  // Carry/borrow are taken from the old value, so wrap is detected before the update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q    <= RESET_VAL;
      sout <= 1'b0;
      co   <= 1'b0;
    end else if (!set_n) begin
      q    <= SET_VAL;
      sout <= 1'b0;
      co   <= 1'b0;
    end else if (en) begin
      case (op)
        MODE_HOLD: ;
        MODE_LOAD: begin
          q  <= d;
          co <= 1'b0;
        end
        MODE_SHL: begin
          q    <= {q[WIDTH-2:0], sin};
          sout <= q[WIDTH-1];
          co   <= 1'b0;
        end
        MODE_SHR: begin
          q    <= {sin, q[WIDTH-1:1]};
          sout <= q[0];
          co   <= 1'b0;
        end
        MODE_ROL: begin
          q    <= {q[WIDTH-2:0], q[WIDTH-1]};
          sout <= q[WIDTH-1];
          co   <= 1'b0;
        end
        MODE_ROR: begin
          q    <= {q[0], q[WIDTH-1:1]};
          sout <= q[0];
          co   <= 1'b0;
        end
        MODE_INC: begin
          q  <= q + 1'b1;
          co <= &q;
        end
        MODE_DEC: begin
          q  <= q - 1'b1;
          co <= ~|q;
        end
        default: ;
      endcase
    end
  end

  assign zero = (q == '0);

endmodule

// File: doc/_univ_reg_r.md
_UNIV_REG_R -- requirements
Module: _univ_reg_r

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits; legal range 2..64.
REQ-002 The block SHALL have parameter RESET_VAL, default 0 (WIDTH bits), meaning the q value loaded by asynchronous reset.
REQ-003 The block SHALL have parameter SET_VAL, default all ones (WIDTH bits), meaning the q value loaded by synchronous set.
REQ-004 The block SHALL have port clk  input  1  the only clock; all state changes occur on its rising edge except reset.
REQ-005 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port set_n  input  1  synchronous, active-low set.
REQ-007 The block SHALL have port en  input  1  operation enable.
REQ-008 The block SHALL have port mode  input  3  operation select.
REQ-009 The block SHALL have port d  input  WIDTH  parallel load data.
REQ-010 The block SHALL have port sin  input  1  serial input bit for shift modes.
REQ-011 The block SHALL have port q  output  WIDTH  registered register contents.
REQ-012 The block SHALL have port sout  output  1  registered last bit shifted or rotated out.
REQ-013 The block SHALL have port co  output  1  registered carry/borrow from the last increment or decrement.
REQ-014 The block SHALL have port zero  output  1  combinational flag, high when q is all zeros.

Function
REQ-015 Update priority SHALL be: reset_n low (async) > set_n low (sync) > en high with mode > hold.
REQ-016 With set_n low at a clk edge, q SHALL load SET_VAL and sout and co SHALL clear to 0, regardless of en, mode and d.
REQ-017 With set_n high and en low, q, sout and co SHALL all hold.
REQ-018 With set_n high and en high, the next state SHALL follow mode:
- 000 hold: q, sout, co hold.
- 001 load: q<=d; co<=0; sout holds.
- 010 shl: q<={q[WIDTH-2:0],sin}; sout<=q[WIDTH-1]; co<=0.
- 011 shr: q<={sin,q[WIDTH-1:1]}; sout<=q[0]; co<=0.
- 100 rol: q<={q[WIDTH-2:0],q[WIDTH-1]}; sout<=q[WIDTH-1]; co<=0.
- 101 ror: q<={q[0],q[WIDTH-1:1]}; sout<=q[0]; co<=0.
- 110 inc: q<=q+1 modulo 2^WIDTH; co<=1 iff old q was all ones; sout holds.
- 111 dec: q<=q-1 modulo 2^WIDTH; co<=1 iff old q was zero; sout holds.
REQ-019 All operations SHALL complete in one clk cycle; q, sout and co SHALL show the result after the same rising edge, with no pipeline latency.
REQ-020 zero SHALL track q combinationally within the same cycle, including during reset and set.
REQ-021 Wrap-around: inc from all ones SHALL give q=0 and co=1; dec from 0 SHALL give q=all ones and co=1.
REQ-022 Arithmetic SHALL be unsigned and WIDTH bits wide; no bits beyond WIDTH SHALL be stored.
REQ-023 mode and d SHALL be sampled only at the clk edge; changing them between edges SHALL not alter q.

Reset
REQ-024 With reset_n low, q SHALL be RESET_VAL, and sout and co SHALL be 0, immediately and independent of clk.
REQ-025 While reset_n is low, clk edges SHALL have no effect, including edges with set_n low.
REQ-026 An operation in progress when reset_n asserts SHALL be discarded.
REQ-027 The first operation after reset_n deasserts SHALL occur on the first clk edge at which reset_n is sampled high.

Verification
REQ-028 Async reset: WIDTH=8, q=8'hA5; pull reset_n low mid-cycle -> q=8'h00, sout=0, co=0, zero=1 before the next clk edge.
REQ-029 Set priority: set_n=0, en=1, mode=001, d=8'h3C -> after the edge q=8'hFF, co=0; with set_n=0 and en=0 the result is the same.
REQ-030 Shifts: load 8'b1000_0001, then shl with sin=0 -> q=8'b0000_0010, sout=1; then shr with sin=1 -> q=8'b1000_0001, sout=0.
REQ-031 Rotates: q=8'h81, ror -> q=8'hC0, sout=1; rol -> q=8'h81, sout=1.
REQ-032 Wrap: q=8'hFF, inc -> q=8'h00, co=1, zero=1; dec -> q=8'hFF, co=1; inc again -> q=8'h00, co=1; load 8'h05 -> co=0.
REQ-033 Enable/hold: en=0 for 3 cycles with mode=110 -> q, sout and co are unchanged; WIDTH=16 regression repeats REQ-030 to REQ-032 scaled to 16 bits.
